// File: rtl/div_sched.sv
// ---------------------------------------------------------------------------
// div_sched
//   Sequencer between the execute stage and an iterative divider. Accepts
//   DIVU/DIV/MTHI/MTLO ops with a valid/ready handshake, holds the divider
//   start level for the whole operation and owns the HI/LO registers.
//   Uncommitted divisions are aborted on flush; divide-by-zero is answered
//   locally (LO=all ones, HI=dividend) without starting the divider.
//
// Ports
//   clk, resetn                   core clock, async active-low reset
//   req_valid/req_ready           op handshake
//   req_op                        0=DIVU 1=DIV 2=MTHI 3=MTLO
//   req_x, req_y                  dividend (MTxx source), divisor
//   commit                        in-flight division passed commit point
//   flush                         pipeline flush
//   rd_sel, rd_valid              MFxx read: 0=LO 1=HI
//   rd_data, rd_stall             read data (forwarded), retry request
//   div_go/signed/x/y/kill        divider control
//   div_complete, div_s, div_r    divider done pulse, quotient, remainder
//   resp_valid                    HI/LO written by a division (1 cycle)
//   busy                          sequencer not idle
//   err_timeout                   sticky divider timeout flag
// ---------------------------------------------------------------------------
module div_sched #(
  parameter int unsigned TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic        req_ready,
  input  logic        commit,
  input  logic        flush,
  input  logic        rd_sel,
  input  logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_stall,
  output logic        div_go,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  output logic        div_kill,
  input  logic        div_complete,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  output logic        resp_valid,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [1:0] OP_DIVU = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   x_q, x_d;
  logic [31:0]   y_q, y_d;
  logic          signed_q, signed_d;
  logic          committed_q, committed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_q, resp_d;
  logic          err_q, err_d;

  // Commit arriving in the same cycle as a flush still protects the division.
  logic committed_now;
  assign committed_now = committed_q | commit;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    x_d         = x_q;
    y_d         = y_q;
    signed_d    = signed_q;
    committed_d = committed_q;
    cnt_d       = cnt_q;
    resp_d      = 1'b0;
    err_d       = err_q;
    div_kill    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (req_op)
            OP_MTHI: hi_d = req_x;
            OP_MTLO: lo_d = req_x;
            default: begin  // OP_DIVU, OP_DIV
              if (req_y == 32'd0) begin
                lo_d   = 32'hFFFF_FFFF;
                hi_d   = req_x;
                resp_d = 1'b1;
              end else begin
                x_d         = req_x;
                y_d         = req_y;
                signed_d    = (req_op == OP_DIV);
                committed_d = commit;
                cnt_d       = '0;
                state_d     = ST_BUSY;
              end
            end
          endcase
        end
      end

      ST_BUSY: begin
        cnt_d       = cnt_q + 1'b1;
        committed_d = committed_now;
        // Uncommitted flush beats a same-cycle completion: result discarded.
        if (flush && !committed_now) begin
          div_kill = 1'b1;
          state_d  = ST_GAP;
        end else if (div_complete) begin
          lo_d    = div_s;
          hi_d    = div_r;
          resp_d  = 1'b1;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        // One cycle with div_go low lets the divider return to idle.
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      signed_q    <= 1'b0;
      committed_q <= 1'b0;
      cnt_q       <= '0;
      resp_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      x_q         <= x_d;
      y_q         <= y_d;
      signed_q    <= signed_d;
      committed_q <= committed_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
    end
  end

  // Read port: registers already hold the fresh result during GAP; in IDLE a
  // same-cycle MTxx to the selected register is forwarded.
  always_comb begin
    rd_data = rd_sel ? hi_q : lo_q;
    if (state_q == ST_IDLE && req_valid) begin
      if (req_op == OP_MTHI && rd_sel)  rd_data = req_x;
      if (req_op == OP_MTLO && !rd_sel) rd_data = req_x;
    end
  end

  assign rd_stall    = rd_valid && (state_q == ST_BUSY);
  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign div_go      = (state_q == ST_BUSY);
  assign div_signed  = signed_q;
  assign div_x       = x_q;
  assign div_y       = y_q;
  assign resp_valid  = resp_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_div_sched.sv
// ---------------------------------------------------------------------------
// tb_div_sched
//   Directed self-checking bench for div_sched. The divider is played by the
//   bench: it drives div_complete/div_s/div_r with hand-computed results.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_div_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        req_ready;
  logic        commit;
  logic        flush;
  logic        rd_sel;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_stall;
  logic        div_go;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic        div_kill;
  logic        div_complete;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        resp_valid;
  logic        busy;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_sched #(.TIMEOUT(48)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_ready    (req_ready),
    .commit       (commit),
    .flush        (flush),
    .rd_sel       (rd_sel),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_stall     (rd_stall),
    .div_go       (div_go),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_kill     (div_kill),
    .div_complete (div_complete),
    .div_s        (div_s),
    .div_r        (div_r),
    .resp_valid   (resp_valid),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Overall time bound in case the design wedges the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;

    resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_x = '0; req_y = '0;
    commit = 1'b0; flush = 1'b0; rd_sel = 1'b0; rd_valid = 1'b0;
    div_complete = 1'b0; div_s = '0; div_r = '0;

    // ---------------- reset state ----------------
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_go", div_go, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_err", err_timeout, 0);
    check("rst_lo", rd_data, 0);
    check("rst_divx", div_x, 0);
    next();
    resetn = 1'b1;

    // ---------------- DIV -7 / 2, commit one cycle later ----------------
    next();
    req_valid = 1'b1; req_op = 2'd1; req_x = 32'hFFFF_FFF9; req_y = 32'd2;
    #1 check("a_ready_idle", req_ready, 1);
    check("a_go_pre", div_go, 0);
    next();
    req_valid = 1'b0; commit = 1'b1; rd_valid = 1'b1; rd_sel = 1'b0;
    #1 check("a_go_b1", div_go, 1);
    check("a_signed", div_signed, 1);
    check("a_divx", div_x, 32'hFFFF_FFF9);
    check("a_divy", div_y, 32'd2);
    check("a_ready_busy", req_ready, 0);
    check("a_stall_b1", rd_stall, 1);
    next();
    commit = 1'b0;
    #1 check("a_go_b2", div_go, 1);
    check("a_stall_b2", rd_stall, 1);
    next();
    div_complete = 1'b1; div_s = 32'hFFFF_FFFD; div_r = 32'hFFFF_FFFF;
    #1 check("a_go_b3", div_go, 1);
    check("a_stall_b3", rd_stall, 1);
    check("a_resp_b3", resp_valid, 0);
    next();
    div_complete = 1'b0;
    #1 check("a_resp_gap", resp_valid, 1);
    check("a_go_gap", div_go, 0);
    check("a_ready_gap", req_ready, 0);
    check("a_busy_gap", busy, 1);
    check("a_stall_gap", rd_stall, 0);
    check("a_lo_gap", rd_data, 32'hFFFF_FFFD);
    rd_sel = 1'b1;
    #1 check("a_hi_gap", rd_data, 32'hFFFF_FFFF);
    next();
    rd_valid = 1'b0;
    #1 check("a_resp_idle", resp_valid, 0);
    check("a_ready_idle2", req_ready, 1);
    check("a_busy_idle", busy, 0);

    // ---------------- DIVU 100 / 7 with a queued MTHI behind it ----------------
    next();
    req_valid = 1'b1; req_op = 2'd0; req_x = 32'd100; req_y = 32'd7;
    #1 check("b_ready_acc", req_ready, 1);
    next();
    req_op = 2'd2; req_x = 32'h0000_00A5;
    #1 check("b_ready_b1", req_ready, 0);
    check("b_signed", div_signed, 0);
    check("b_go", div_go, 1);
    next();
    #1 check("b_ready_b2", req_ready, 0);
    next();
    div_complete = 1'b1; div_s = 32'd14; div_r = 32'd2;
    #1 check("b_ready_b3", req_ready, 0);
    next();
    div_complete = 1'b0; rd_sel = 1'b0;
    #1 check("b_ready_gap", req_ready, 0);
    check("b_resp_gap", resp_valid, 1);
    check("b_lo_gap", rd_data, 32'd14);
    rd_sel = 1'b1;
    #1 check("b_hi_gap", rd_data, 32'd2);
    next();
    #1 check("b_ready_idle", req_ready, 1);
    check("b_hi_fwd", rd_data, 32'h0000_00A5);
    next();
    req_valid = 1'b0;
    #1 check("b_hi_mthi", rd_data, 32'h0000_00A5);
    rd_sel = 1'b0;
    #1 check("b_lo_keep", rd_data, 32'd14);

    // ---------------- flush in IDLE is ignored ----------------
    flush = 1'b1;
    #1 check("c_kill_idle", div_kill, 0);
    next();
    flush = 1'b0;
    #1 check("c_busy_idle", busy, 0);

    // ---------------- DIV flushed before commit (with same-cycle complete) ----------------
    next();
    req_valid = 1'b1; req_op = 2'd1; req_x = 32'd50; req_y = 32'd3;
    next();
    req_valid = 1'b0;
    next();
    next();
    next();
    next();
    flush = 1'b1; div_complete = 1'b1; div_s = 32'h0000_DEAD; div_r = 32'h0000_BEEF;
    #1 check("c_kill", div_kill, 1);
    check("c_go_flush", div_go, 1);
    next();
    flush = 1'b0; div_complete = 1'b0;
    #1 check("c_kill_gap", div_kill, 0);
    check("c_resp_gap", resp_valid, 0);
    check("c_go_gap", div_go, 0);
    check("c_busy_gap", busy, 1);
    rd_sel = 1'b1;
    #1 check("c_hi_kept", rd_data, 32'h0000_00A5);
    rd_sel = 1'b0;
    #1 check("c_lo_kept", rd_data, 32'd14);
    next();
    #1 check("c_resp_idle", resp_valid, 0);
    check("c_ready_idle", req_ready, 1);

    // ---------------- DIV committed, then flushed: flush ignored ----------------
    req_valid = 1'b1; req_op = 2'd1; req_x = 32'd50; req_y = 32'd3;
    next();
    req_valid = 1'b0; commit = 1'b1;
    next();
    commit = 1'b0; flush = 1'b1;
    #1 check("d_kill", div_kill, 0);
    next();
    flush = 1'b0;
    #1 check("d_go_after", div_go, 1);
    div_complete = 1'b1; div_s = 32'd16; div_r = 32'd2;
    next();
    div_complete = 1'b0;
    #1 check("d_resp", resp_valid, 1);
    check("d_lo", rd_data, 32'd16);
    rd_sel = 1'b1;
    #1 check("d_hi", rd_data, 32'd2);
    next();

    // ---------------- DIVU by zero ----------------
    req_valid = 1'b1; req_op = 2'd0; req_x = 32'h0000_1234; req_y = 32'd0;
    #1 check("e_go_acc", div_go, 0);
    next();
    req_valid = 1'b0;
    #1 check("e_go", div_go, 0);
    check("e_busy", busy, 0);
    check("e_resp", resp_valid, 1);
    check("e_ready", req_ready, 1);
    check("e_hi", rd_data, 32'h0000_1234);
    rd_sel = 1'b0;
    #1 check("e_lo", rd_data, 32'hFFFF_FFFF);
    next();
    #1 check("e_resp_off", resp_valid, 0);

    // ---------------- MTLO with same-cycle MFLO ----------------
    req_valid = 1'b1; req_op = 2'd3; req_x = 32'h0000_0055; rd_valid = 1'b1; rd_sel = 1'b0;
    #1 check("f_fwd", rd_data, 32'h0000_0055);
    check("f_stall", rd_stall, 0);
    next();
    req_valid = 1'b0; rd_valid = 1'b0;
    #1 check("f_lo", rd_data, 32'h0000_0055);

    // ---------------- divider never completes: timeout ----------------
    next();
    req_valid = 1'b1; req_op = 2'd0; req_x = 32'd1; req_y = 32'd1;
    next();
    req_valid = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!div_go) break;
      busy_cycles++;
      if (busy_cycles == 47) check("g_err_early", err_timeout, 0);
      next();
    end
    check("g_busy_cycles", busy_cycles, 48);
    check("g_err", err_timeout, 1);
    check("g_gap", busy, 1);
    check("g_lo_kept", rd_data, 32'h0000_0055);
    rd_sel = 1'b1;
    #1 check("g_hi_kept", rd_data, 32'h0000_1234);
    next();
    #1 check("g_idle", busy, 0);
    check("g_ready", req_ready, 1);
    check("g_err_sticky", err_timeout, 1);

    // ---------------- asynchronous reset mid-division ----------------
    req_valid = 1'b1; req_op = 2'd0; req_x = 32'd9; req_y = 32'd3;
    next();
    req_valid = 1'b0;
    #1 check("h_go", div_go, 1);
    #2 resetn = 1'b0;
    #1 check("h_go_rst", div_go, 0);
    check("h_busy_rst", busy, 0);
    check("h_ready_rst", req_ready, 1);
    check("h_err_rst", err_timeout, 0);
    check("h_divx_rst", div_x, 0);
    check("h_hi_rst", rd_data, 0);
    rd_sel = 1'b0;
    #1 check("h_lo_rst", rd_data, 0);
    next();
    resetn = 1'b1;
    next();
    #1 check("h_ready_after", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
